// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// pulse_pkg
//   Types and constants shared by the pulse generator and the frame reader.
//   Rev 1.0
// ============================================================================
package pulse_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } pulse_state_e;

    localparam int          PULSE_DEPTH     = 2048;
    localparam int          PULSE_ADDR_STEP = 4;
    localparam int          PULSE_IDX_W     = 11;
    localparam logic [31:0] FP32_ZERO       = 32'h0;

endpackage
`default_nettype wire

// File: rtl/pulse_frame_reader.sv
`default_nettype none
// ============================================================================
// pulse_frame_reader
//   Sweeps the pulse BRAM word by word, streams each sample out over
//   valid/ready and optionally clears the word behind the read.
//   Rev 1.0
// ============================================================================
module pulse_frame_reader
    import pulse_pkg::*;
#(
    parameter int DEPTH     = PULSE_DEPTH,
    parameter int ADDR_STEP = PULSE_ADDR_STEP,
    parameter int CLEAR_EN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] bram_addr_pulse,
    output logic [31:0] bram_data_in_pulse,
    output logic        bram_we_pulse,
    output logic        ena_pulse,
    input  logic [31:0] bram_data_out_pulse,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [10:0] sample_index,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [PULSE_IDX_W-1:0] c_last_idx = PULSE_IDX_W'(DEPTH - 1);
    localparam logic                   c_clear    = (CLEAR_EN != 0);

    pulse_state_e           state_q, state_d;
    logic [PULSE_IDX_W-1:0] idx_q, idx_d;
    logic [PULSE_IDX_W-1:0] index_q, index_d;
    logic [31:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ena_q, ena_d;
    logic                   we_q, we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ena_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ena_q   <= ena_d;
            we_q    <= we_d;
        end
    end

    // BRAM strobes default low so the clear write spans one OUT cycle only,
    // and an abort on the WT->OUT edge drops it before it is ever driven.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        ena_d   = 1'b0;
        we_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RD;
                        idx_d   = '0;
                        ena_d   = 1'b1;
                    end
                end
                RD: begin
                    state_d = WT;
                end
                WT: begin
                    data_d  = bram_data_out_pulse;
                    index_d = idx_q;
                    valid_d = 1'b1;
                    ena_d   = c_clear;
                    we_d    = c_clear;
                    state_d = OUT;
                end
                OUT: begin
                    if (valid_q && sample_ready) begin
                        valid_d = 1'b0;
                        if (idx_q == c_last_idx) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            ena_d   = 1'b1;
                            state_d = RD;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign busy               = (state_q != IDLE);
    assign frame_done         = (state_q == DONE);
    assign bram_addr_pulse    = busy ? (32'(idx_q) * 32'(ADDR_STEP)) : 32'h0;
    assign bram_data_in_pulse = FP32_ZERO;
    assign bram_we_pulse      = we_q;
    assign ena_pulse          = ena_q;
    assign sample_data        = data_q;
    assign sample_valid       = valid_q;
    assign sample_index       = index_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_pulse_frame_reader
//   Directed bench: instance A clears behind the read, instance B does not.
//   Rev 1.0
// ============================================================================
module tb_pulse_frame_reader;

    localparam int DEPTH = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
    logic [31:0] addr_a, din_a, dout_a, data_a;
    logic [31:0] addr_b, din_b, dout_b, data_b;
    logic        we_a, ena_a, valid_a, busy_a, done_a;
    logic        we_b, ena_b, valid_b, busy_b, done_b;
    logic [10:0] idx_a, idx_b;

    pulse_frame_reader #(.DEPTH(DEPTH), .ADDR_STEP(4), .CLEAR_EN(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .bram_addr_pulse(addr_a), .bram_data_in_pulse(din_a),
        .bram_we_pulse(we_a), .ena_pulse(ena_a),
        .bram_data_out_pulse(dout_a), .sample_data(data_a),
        .sample_valid(valid_a), .sample_ready(ready_a),
        .sample_index(idx_a), .busy(busy_a), .frame_done(done_a)
    );

    pulse_frame_reader #(.DEPTH(DEPTH), .ADDR_STEP(4), .CLEAR_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .bram_addr_pulse(addr_b), .bram_data_in_pulse(din_b),
        .bram_we_pulse(we_b), .ena_pulse(ena_b),
        .bram_data_out_pulse(dout_b), .sample_data(data_b),
        .sample_valid(valid_b), .sample_ready(ready_b),
        .sample_index(idx_b), .busy(busy_b), .frame_done(done_b)
    );

    // Read-first BRAM models with a bench-side preload/clear port
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic        pl_clr = 1'b0, pl_en = 1'b0, pl_sel = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
        end else if (pl_en && !pl_sel) begin
            mem_a[pl_addr] <= pl_data;
        end else if (ena_a) begin
            if (we_a) mem_a[addr_a[12:2]] <= din_a;
            dout_a <= mem_a[addr_a[12:2]];
        end
    end

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < DEPTH; i++) mem_b[i] <= '0;
        end else if (pl_en && pl_sel) begin
            mem_b[pl_addr] <= pl_data;
        end else if (ena_b) begin
            if (we_b) mem_b[addr_b[12:2]] <= din_b;
            dout_b <= mem_b[addr_b[12:2]];
        end
    end

    typedef struct packed {
        logic        busy, valid, ena, we, done;
        logic [31:0] addr, data, din;
        logic [10:0] idx;
    } outs_t;

    typedef struct packed {
        logic        start, ready;
        logic        busy, ena, we, valid, done;
        logic [31:0] addr;
        logic [10:0] idx;
    } vec_t;

    int          n_chk = 0, n_err = 0, cyc = 0;
    int          ena_cnt [2], we_cnt [2], xfer_cnt [2], done_cnt [2], done_cyc [2], exp_idx [2];
    logic [31:0] we_addr [2];
    logic        seen5 [2];
    logic [31:0] exp_mem [2][DEPTH];
    vec_t        vecs [7];

    function automatic outs_t get_outs(input int d);
        outs_t o;
        if (d == 0) begin
            o.busy = busy_a; o.valid = valid_a; o.ena = ena_a; o.we = we_a; o.done = done_a;
            o.addr = addr_a; o.data = data_a; o.din = din_a; o.idx = idx_a;
        end else begin
            o.busy = busy_b; o.valid = valid_b; o.ena = ena_b; o.we = we_b; o.done = done_b;
            o.addr = addr_b; o.data = data_b; o.din = din_b; o.idx = idx_b;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observe the current cycle of both instances, then advance one clock.
    task automatic tick();
        outs_t o;
        logic  rdy;
        for (int d = 0; d < 2; d++) begin
            o   = get_outs(d);
            rdy = (d == 0) ? ready_a : ready_b;
            if (o.ena) ena_cnt[d]++;
            if (o.we) begin
                we_cnt[d]++;
                we_addr[d] = o.addr;
            end
            if (o.valid && rdy) begin
                chk("xfer_index", {21'd0, o.idx}, exp_idx[d]);
                chk("xfer_data", o.data, exp_mem[d][o.idx]);
                if (o.idx == 11'd5 && o.data == 32'h3F59AD43) seen5[d] = 1'b1;
                xfer_cnt[d]++;
                exp_idx[d]++;
            end
            if (o.done) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input logic sel, input logic [10:0] a, input logic [31:0] v);
        pl_sel  = sel;
        pl_addr = a;
        pl_data = v;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic run_frame(input int d, input int budget);
        int base;
        base = done_cnt[d];
        for (int i = 0; i < budget; i++) begin
            if (done_cnt[d] != base) break;
            tick();
        end
        chk("frame_done_count", done_cnt[d] - base, 1);
    endtask

    function automatic logic at_rd(input int d, input logic [31:0] a);
        outs_t o;
        o = get_outs(d);
        return o.ena && !o.we && (o.addr == a);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t o;
        int    rd0, nz, e0, w0, dc;
        logic  found;

        for (int d = 0; d < 2; d++) begin
            ena_cnt[d] = 0; we_cnt[d] = 0; xfer_cnt[d] = 0; done_cnt[d] = 0;
            done_cyc[d] = 0; exp_idx[d] = 0; we_addr[d] = '0; seen5[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) exp_mem[d][i] = '0;
        end
        exp_mem[0][5] = 32'h3F59AD43;
        exp_mem[1][5] = 32'h3F59AD43;

        //            start ready busy ena  we   valid done  addr    idx
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 11'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 11'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 11'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4, 11'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 11'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 11'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8, 11'd1};

        // Reset state
        #2 rst_n = 1'b0;
        pl_clr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pl_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            o = get_outs(d);
            chk1("reset_busy", o.busy, 1'b0);
            chk1("reset_valid", o.valid, 1'b0);
            chk1("reset_ena", o.ena, 1'b0);
            chk1("reset_we", o.we, 1'b0);
            chk1("reset_done", o.done, 1'b0);
            chk("reset_addr", o.addr, 32'd0);
            chk("reset_data", o.data, 32'd0);
            chk("reset_index", {21'd0, o.idx}, 32'd0);
        end
        rst_n = 1'b1;
        preload(1'b0, 11'd5, 32'h3F59AD43);
        preload(1'b1, 11'd5, 32'h3F59AD43);

        // Test 1: full frame with read-and-clear, first words cycle by cycle
        rd0 = 0;
        for (int i = 0; i < 7; i++) begin
            start_a = vecs[i].start;
            ready_a = vecs[i].ready;
            tick();
            if (i == 0) rd0 = cyc;
            o = get_outs(0);
            chk1($sformatf("vec%0d_busy", i), o.busy, vecs[i].busy);
            chk1($sformatf("vec%0d_ena", i), o.ena, vecs[i].ena);
            chk1($sformatf("vec%0d_we", i), o.we, vecs[i].we);
            chk1($sformatf("vec%0d_valid", i), o.valid, vecs[i].valid);
            chk1($sformatf("vec%0d_done", i), o.done, vecs[i].done);
            chk($sformatf("vec%0d_addr", i), o.addr, vecs[i].addr);
            chk($sformatf("vec%0d_index", i), {21'd0, vecs[i].idx}, {21'd0, o.idx});
        end
        run_frame(0, 7000);
        chk("a_done_latency", 32'(done_cyc[0] - rd0 + 1), 32'(3 * DEPTH + 1));
        chk("a_xfer_count", xfer_cnt[0], DEPTH);
        chk("a_we_count", we_cnt[0], DEPTH);
        chk1("a_seen_word5", seen5[0], 1'b1);
        o = get_outs(0);
        chk1("a_done_pulse_len", o.done, 1'b0);
        chk1("a_idle_after_frame", o.busy, 1'b0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_a[i] != 32'd0) nz++;
        chk("a_readback_nonzero_words", nz, 0);

        // Test 2: same frame without clearing
        exp_idx[1] = 0;
        start_b = 1'b1;
        ready_b = 1'b1;
        tick();
        rd0 = cyc;
        start_b = 1'b0;
        chk1("b_rd0_ena", ena_b, 1'b1);
        run_frame(1, 7000);
        chk("b_done_latency", 32'(done_cyc[1] - rd0 + 1), 32'(3 * DEPTH + 1));
        chk("b_xfer_count", xfer_cnt[1], DEPTH);
        chk("b_we_count", we_cnt[1], 0);
        chk1("b_seen_word5", seen5[1], 1'b1);
        chk("b_word5_kept", mem_b[5], 32'h3F59AD43);

        // Test 3: stall at index 7
        preload(1'b0, 11'd7, 32'h40490FDB);
        exp_mem[0][5] = 32'd0;
        exp_mem[0][7] = 32'h40490FDB;
        exp_idx[0] = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (at_rd(0, 32'd28)) begin found = 1'b1; break; end
            tick();
        end
        chk1("reach_rd7", found, 1'b1);
        ready_a = 1'b0;
        tick();
        tick();
        e0 = ena_cnt[0];
        w0 = we_cnt[0];
        for (int k = 0; k < 10; k++) begin
            o = get_outs(0);
            chk1("stall_valid", o.valid, 1'b1);
            chk("stall_data", o.data, 32'h40490FDB);
            chk("stall_index", {21'd0, o.idx}, 32'd7);
            tick();
        end
        chk("stall_ena_cycles", ena_cnt[0] - e0, 1);
        chk("stall_we_cycles", we_cnt[0] - w0, 1);
        chk("stall_we_addr", we_addr[0], 32'd28);
        ready_a = 1'b1;
        tick();
        exp_mem[0][7] = 32'd0;
        chk("word7_cleared", mem_a[7], 32'd0);

        // Test 4: abort in OUT at index 100
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            o = get_outs(0);
            if (o.valid && o.idx == 11'd100) begin found = 1'b1; break; end
            tick();
        end
        chk1("reach_out100", found, 1'b1);
        abort_a = 1'b1;
        ready_a = 1'b0;
        tick();
        abort_a = 1'b0;
        o = get_outs(0);
        chk1("abort_busy", o.busy, 1'b0);
        chk1("abort_valid", o.valid, 1'b0);
        chk1("abort_we", o.we, 1'b0);
        chk1("abort_ena", o.ena, 1'b0);
        chk("abort_addr", o.addr, 32'd0);
        dc = done_cnt[0];
        tick(); tick(); tick();
        chk("abort_no_frame_done", done_cnt[0] - dc, 0);

        // Test 5: restart from 0, then start while busy is ignored
        preload(1'b0, 11'd49, 32'hC0000000);
        exp_mem[0][49] = 32'hC0000000;
        exp_idx[0] = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        o = get_outs(0);
        chk1("restart_ena", o.ena, 1'b1);
        chk("restart_addr", o.addr, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (at_rd(0, 32'd12)) begin found = 1'b1; break; end
            tick();
        end
        chk1("reach_rd3", found, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        o = get_outs(0);
        chk1("busy_start_busy", o.busy, 1'b1);
        chk1("busy_start_ena", o.ena, 1'b0);
        chk("busy_start_addr", o.addr, 32'd12);
        for (int k = 0; k < 20; k++) begin
            if (exp_idx[0] >= 5) break;
            tick();
        end
        chk("busy_start_progress", exp_idx[0], 5);

        // Test 6: asynchronous reset during WT at index 50
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            o = get_outs(0);
            if (o.busy && !o.ena && !o.valid && o.addr == 32'd200) begin found = 1'b1; break; end
            tick();
        end
        chk1("reach_wt50", found, 1'b1);
        chk("pre_reset_data", data_a, 32'hC0000000);
        rst_n = 1'b0;
        #1;
        o = get_outs(0);
        chk1("areset_busy", o.busy, 1'b0);
        chk1("areset_valid", o.valid, 1'b0);
        chk1("areset_ena", o.ena, 1'b0);
        chk1("areset_we", o.we, 1'b0);
        chk1("areset_done", o.done, 1'b0);
        chk("areset_addr", o.addr, 32'd0);
        chk("areset_data", o.data, 32'd0);
        chk("areset_index", {21'd0, o.idx}, 32'd0);
        chk("areset_din", o.din, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("post_reset_idle", busy_a, 1'b0);
        end
        exp_idx[0] = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        o = get_outs(0);
        chk1("post_reset_start_busy", o.busy, 1'b1);
        chk1("post_reset_start_ena", o.ena, 1'b1);
        chk("post_reset_start_addr", o.addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_frame_reader.md
Name: pulse_frame_reader

Overview:
- Downstream stage of the pulse generator.
- Sweeps the pulse-accumulation BRAM one word at a time, from word 0 to DEPTH-1.
- Streams each fp32 sample out over a valid/ready interface to the DAC/analysis path.
- Optionally writes 0 back to each word after reading it (read-and-clear), so the generator starts the next frame on an empty buffer.

Parameters:
- DEPTH, 2048, number of 32-bit words swept per frame (matches the 11-bit LFSR address range).
- ADDR_STEP, 4, byte-address increment per word.
- CLEAR_EN, 1, when 1, write 32'h0 to each word after reading it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle, ignored while busy.
- abort  in  1  synchronous; ends the frame at the next edge.
- bram_addr_pulse  out  32  BRAM byte address.
- bram_data_in_pulse  out  32  BRAM write data (always 0).
- bram_we_pulse  out  1  BRAM write enable.
- ena_pulse  out  1  BRAM enable.
- bram_data_out_pulse  in  32  BRAM read data, valid one cycle after a read.
- sample_data  out  32  fp32 sample.
- sample_valid  out  1  sample_data holds an untaken sample.
- sample_ready  in  1  consumer accepts the sample.
- sample_index  out  11  word index of sample_data.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse after the last sample transfers.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, RD, WT, OUT, DONE.
- IDLE:
  - start=1 -> RD with idx=0.
  - All BRAM controls are 0.
- RD (1 cycle):
  - ena_pulse=1, bram_we_pulse=0, bram_addr_pulse=idx*ADDR_STEP.
  - -> WT.
- WT (1 cycle):
  - ena_pulse=0; the read data appears on bram_data_out_pulse.
  - At the end of WT: sample_data<=bram_data_out_pulse, sample_index<=idx, sample_valid<=1.
  - If CLEAR_EN=1, also ena_pulse<=1, bram_we_pulse<=1, bram_data_in_pulse<=0, with the address held.
  - -> OUT.
- OUT:
  - The clear write lasts exactly the first OUT cycle; we/ena then return to 0.
  - Hold sample_valid and sample_data stable until sample_valid&&sample_ready.
  - On transfer: sample_valid<=0; if idx==DEPTH-1 -> DONE, else idx<=idx+1 -> RD.
- DONE (1 cycle): frame_done=1 -> IDLE.
- Throughput: 3 cycles per sample with sample_ready held high. A full frame is 3*DEPTH cycles from RD of word 0 to the last transfer, plus 1 cycle for DONE.
- sample_ready low in OUT: stall indefinitely. The clear write has already happened; no BRAM re-access.
- sample_ready high before sample_valid: no effect.
- abort:
  - Takes priority over every transition; -> IDLE at the next edge.
  - sample_valid, ena_pulse, bram_we_pulse <= 0.
  - No frame_done is issued.
  - A clear write issued in the same edge as abort is suppressed: we must not be asserted after the abort edge.
- start while busy: ignored. start and abort in the same cycle while IDLE: stay in IDLE.
- idx is 11 bits. Address = {idx,2'b00} zero-extended to 32 bits. There is no wrap: the sweep stops at DEPTH-1.
- Reset mid-frame: all outputs go to 0 immediately; BRAM contents are left as they are.
- sample_data is passed through bit-exact. There is no fp arithmetic in this block.

Decomposition:
- Shared package pulse_pkg holds:
  - state enum (IDLE, RD, WT, OUT, DONE);
  - PULSE_DEPTH=2048, PULSE_ADDR_STEP=4;
  - FP32_ZERO=32'h0.
  These constants are shared with the generator.
- No sub-module: a single FSM with an index counter. The BRAM model is instantiated only in the bench.

Test Plan:
1. Preload BRAM word 5=32'h3F59AD43, all others 0. Pulse start with ready=1 -> 2048 transfers; the transfer with sample_index=5 carries 3F59AD43. frame_done fires exactly 3*2048+1 cycles after RD of word 0. A BRAM readback afterwards gives all zeros.
2. Repeat test 1 with CLEAR_EN=0 -> same output stream; BRAM word 5 still reads 3F59AD43.
3. Hold ready=0 for 10 cycles at index 7 -> sample_valid stays high and sample_data/sample_index stay stable. Exactly one write to address 28 occurs, and no other BRAM activity during the stall.
4. Assert abort in the OUT state at index 100 -> next cycle busy=0, sample_valid=0, we=0, and no frame_done. A new start restarts at index 0.
5. Pulse start while busy=1 at index 3 -> no effect; the frame continues.
6. Drive rst_n=0 during WT at index 50 -> all outputs 0 asynchronously. After release, busy=0 until the next start.
